hazard_controller: RTL

Hazard and multiply-sequencing controller for the five-stage pipelined MIPS datapath. It watches the register addresses, write enables and writeback-source codes that the datapath exports from D, E, M and W. From these it drives the datapath's stall, flush and forwarding controls. It also tracks the multi-cycle multiplier with a small state machine and watchdog, and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Hazard unit for the five-stage MIPS pipeline: forwarding selects, load/branch/multiply
// stalls, a multiply watchdog FSM and a saturating stall-cycle counter.
module hazard_controller #(
    parameter int MULT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branchD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             MultStartD,
    input  logic [2:0]       WBSrcD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MultStartE,
    input  logic             MultDoneE,
    input  logic [2:0]       WBSrcE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic [2:0]       WBSrcM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mult_busy,
    output logic             mult_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] WB_LOAD = 3'b001;
    localparam logic [2:0] WB_HI   = 3'b011;
    localparam logic [2:0] WB_LO   = 3'b100;
    localparam logic [7:0] WDOG_LAST = 8'(MULT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, TIMEOUT} multState_t;

    multState_t       state;
    logic [7:0]       wdog;
    logic [CNT_W-1:0] stallCnt;
    logic             multTimeout;

    logic       lwStall, branchStall, multStall, stall;
    logic [1:0] fwdAE, fwdBE;
    logic       fwdAD, fwdBD;

    // r0 is hardwired to zero, so it must never create a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic wrM,
                                          input logic [4:0] regM, input logic wrW,
                                          input logic [4:0] regW);
        if (wrM && regMatch(regM, src))      return 2'b10;
        else if (wrW && regMatch(regW, src)) return 2'b01;
        else                                 return 2'b00;
    endfunction

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        lwStall     = (WBSrcE == WB_LOAD) && (regMatch(RtE, RsD) || regMatch(RtE, RtD));
        branchStall = (branchD != 2'b00) &&
                      ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                       ((WBSrcM == WB_LOAD) && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
        multStall   = (state == BUSY) && !MultDoneE &&
                      (MultStartD || (WBSrcD == WB_HI) || (WBSrcD == WB_LO));
        stall       = lwStall | branchStall | multStall;
        fwdAE       = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        fwdBE       = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        fwdAD       = RegWriteM && regMatch(WriteRegM, RsD);
        fwdBD       = RegWriteM && regMatch(WriteRegM, RtD);
    end

    // While reset is held the pipeline is frozen into a bubble regardless of the inputs.
    assign stallF       = rst & stall;
    assign stallD       = rst & stall;
    assign flushE       = ~rst | stall;
    assign forwardAE    = rst ? fwdAE : 2'b00;
    assign forwardBE    = rst ? fwdBE : 2'b00;
    assign forwardAD    = rst & fwdAD;
    assign forwardBD    = rst & fwdBD;
    assign mult_busy    = rst & (state == BUSY);
    assign mult_timeout = multTimeout;
    assign stall_cycles = stallCnt;

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wdog        <= 8'd0;
            stallCnt    <= '0;
            multTimeout <= 1'b0;
        end else begin
            if (stallF && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
            case (state)
                IDLE: begin
                    // A zero-latency multiply completes in E and never enters BUSY.
                    if (MultStartE && !MultDoneE) begin
                        state <= BUSY;
                        wdog  <= 8'd0;
                    end
                end
                BUSY: begin
                    if (MultDoneE) begin
                        state <= IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        state       <= TIMEOUT;
                        multTimeout <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                TIMEOUT: multTimeout <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
